// File: rtl/i2c_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_adc_responder
// Brief    : I2C target emulating a 12-bit ADC (config byte in, sample out).
//            Optional input filter enabled by defining I2C_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_adc_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h28,
  parameter logic [7:0] RESET_CFG = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [11:0] sample_data,
  output logic [7:0]  config_byte,
  output logic        config_valid,
  output logic        read_done,
  output logic        busy
);

  localparam logic [2:0] c_bit_msb = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_TX        = 3'd3,
    S_TX_ACK    = 3'd4,
    S_RX        = 3'd5,
    S_RX_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        w_scl_s, w_sda_s;
  logic        w_scl, w_sda;
  logic        r_scl_d, r_sda_d;
  logic        w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic        w_start, w_stop;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_next;
  logic        r_got8;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic [11:0] r_shadow;
  logic [7:0]  r_tx_byte;
  logic        r_byte1_next;
  logic        r_acked;
  logic        r_sda_oe;
  logic [7:0]  r_config_byte;
  logic        r_config_valid;
  logic        r_read_done;
  logic        r_busy;
  logic [7:0]  w_byte0_held;
  logic [7:0]  w_byte0_fresh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

  assign w_scl_s = r_scl_sync[1];
  assign w_sda_s = r_sda_sync[1];

`ifdef I2C_GLITCH_FILTER_EN
  logic       r_scl_flt, r_sda_flt;
  logic [1:0] r_scl_cnt, r_sda_cnt;

  // Output follows the input only once it has disagreed for 3 consecutive clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
      r_scl_cnt <= 2'd0;
      r_sda_cnt <= 2'd0;
    end else begin
      if (w_scl_s == r_scl_flt) begin
        r_scl_cnt <= 2'd0;
      end else if (r_scl_cnt == 2'd2) begin
        r_scl_flt <= w_scl_s;
        r_scl_cnt <= 2'd0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 2'd1;
      end
      if (w_sda_s == r_sda_flt) begin
        r_sda_cnt <= 2'd0;
      end else if (r_sda_cnt == 2'd2) begin
        r_sda_flt <= w_sda_s;
        r_sda_cnt <= 2'd0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 2'd1;
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = w_scl_s;
  assign w_sda = w_sda_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise    = w_scl & ~r_scl_d;
  assign w_scl_fall    = ~w_scl & r_scl_d;
  assign w_sda_rise    = w_sda & ~r_sda_d;
  assign w_sda_fall    = ~w_sda & r_sda_d;
  assign w_start       = w_sda_fall & w_scl & r_scl_d;
  assign w_stop        = w_sda_rise & w_scl & r_scl_d;
  assign w_bit_next    = r_bit_cnt - 3'd1;
  assign w_byte0_held  = {4'b0000, r_shadow[11:8]};
  assign w_byte0_fresh = {4'b0000, sample_data[11:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= c_bit_msb;
      r_got8         <= 1'b0;
      r_shift        <= 8'h00;
      r_rw           <= 1'b0;
      r_shadow       <= 12'h000;
      r_tx_byte      <= 8'h00;
      r_byte1_next   <= 1'b0;
      r_acked        <= 1'b0;
      r_sda_oe       <= 1'b0;
      r_config_byte  <= RESET_CFG;
      r_config_valid <= 1'b0;
      r_read_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_config_valid <= 1'b0;
      r_read_done    <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_bit_cnt <= c_bit_msb;
        r_got8    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt == 3'd0) r_got8 <= 1'b1;
              else                   r_bit_cnt <= w_bit_next;
            end else if (w_scl_fall && r_got8) begin
              r_rw <= r_shift[0];
              if (r_shift[0]) r_shadow <= sample_data;
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state  <= S_ADDR_ACK;
                r_sda_oe <= 1'b1;
              end else begin
                r_state  <= S_WAIT_STOP;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= c_bit_msb;
              r_got8    <= 1'b0;
              if (r_rw) begin
                r_state      <= S_TX;
                r_tx_byte    <= w_byte0_held;
                r_sda_oe     <= ~w_byte0_held[7];
                r_byte1_next <= 1'b1;
              end else begin
                r_state  <= S_RX;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_TX: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_state  <= S_TX_ACK;
                r_sda_oe <= 1'b0;
                r_acked  <= 1'b0;
              end else begin
                r_bit_cnt <= w_bit_next;
                r_sda_oe  <= ~r_tx_byte[w_bit_next];
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_acked <= 1'b1;
              end else begin
                r_state     <= S_WAIT_STOP;
                r_read_done <= 1'b1;
              end
            end else if (w_scl_fall && r_acked) begin
              r_state   <= S_TX;
              r_bit_cnt <= c_bit_msb;
              if (r_byte1_next) begin
                r_tx_byte    <= r_shadow[7:0];
                r_sda_oe     <= ~r_shadow[7];
                r_byte1_next <= 1'b0;
              end else begin
                // Pair complete: take a new sample so both bytes stay coherent.
                r_shadow     <= sample_data;
                r_tx_byte    <= w_byte0_fresh;
                r_sda_oe     <= ~w_byte0_fresh[7];
                r_byte1_next <= 1'b1;
              end
            end
          end
          S_RX: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt == 3'd0) r_got8 <= 1'b1;
              else                   r_bit_cnt <= w_bit_next;
            end else if (w_scl_fall && r_got8) begin
              r_state        <= S_RX_ACK;
              r_sda_oe       <= 1'b1;
              r_config_byte  <= r_shift;
              r_config_valid <= 1'b1;
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              r_state   <= S_RX;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= c_bit_msb;
              r_got8    <= 1'b0;
            end
          end
          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe       = r_sda_oe;
  assign config_byte  = r_config_byte;
  assign config_valid = r_config_valid;
  assign read_done    = r_read_done;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_adc_responder
// Brief    : Bit-banged I2C master driving i2c_adc_responder with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_adc_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_low_m = 1'b0;
  logic [11:0] sample_data = 12'h000;
  logic        sda_oe;
  logic [7:0]  config_byte;
  logic        config_valid;
  logic        read_done;
  logic        busy;
  wire         sda_bus = ~(sda_low_m | sda_oe);

  always #5 clk = ~clk;

  i2c_adc_responder #(.DEV_ADDR(7'h28), .RESET_CFG(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .sample_data (sample_data),
    .config_byte (config_byte),
    .config_valid(config_valid),
    .read_done   (read_done),
    .busy        (busy)
  );

  string       exp_nm[$];
  logic [15:0] exp_v[$];
  logic [15:0] obs_v[$];
  logic [7:0]  exp_cfg[$];
  int          checks = 0, errors = 0;
  int          cfg_pulses = 0, rd_pulses = 0, oe_hi = 0;
  bit          done = 1'b0, drained = 1'b0;

  task automatic expect_v(input string nm, input logic [15:0] v);
    exp_nm.push_back(nm);
    exp_v.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    obs_v.push_back(v);
  endtask

  // Monitor: pairs observations with expectations and checks every config write.
  always @(negedge clk) begin : mon
    int          nc, ne;
    string       nm;
    logic [15:0] ev, av;
    logic [7:0]  e8;
    nc = 0;
    ne = 0;
    if (exp_v.size() > 0 && obs_v.size() > 0) begin
      nm = exp_nm.pop_front();
      ev = exp_v.pop_front();
      av = obs_v.pop_front();
      nc++;
      if (av !== ev) begin
        ne++;
        $display("FAIL %s actual=%h required=%h", nm, av, ev);
      end
    end
    if (config_valid) begin
      cfg_pulses <= cfg_pulses + 1;
      nc++;
      if (exp_cfg.size() == 0) begin
        ne++;
        $display("FAIL cfg_unexpected actual=%h required=none", config_byte);
      end else begin
        e8 = exp_cfg.pop_front();
        if (config_byte !== e8) begin
          ne++;
          $display("FAIL cfg_value actual=%h required=%h", config_byte, e8);
        end
      end
    end
    if (read_done) rd_pulses <= rd_pulses + 1;
    if (sda_oe)    oe_hi <= oe_hi + 1;
    if (done && !drained) begin
      nc++;
      if (exp_v.size() != 0 || obs_v.size() != 0 || exp_cfg.size() != 0) begin
        ne++;
        $display("FAIL leftover actual=%0d/%0d/%0d required=0/0/0",
                 exp_v.size(), obs_v.size(), exp_cfg.size());
      end
      drained <= 1'b1;
    end
    checks <= checks + nc;
    errors <= errors + ne;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start;
    sda_low_m = 1'b0; tick(Q);
    scl_m = 1'b1;     tick(Q);
    sda_low_m = 1'b1; tick(Q);
    scl_m = 1'b0;     tick(Q);
  endtask

  task automatic i2c_stop;
    sda_low_m = 1'b1; tick(Q);
    scl_m = 1'b1;     tick(Q);
    sda_low_m = 1'b0; tick(2 * Q);
  endtask

  task automatic put_bit(input bit b, input bit glitch);
    sda_low_m = ~b;
    if (glitch) begin
      tick(Q / 2); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q / 2 - 1);
      scl_m = 1'b1;
      tick(Q); scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(Q - 1);
    end else begin
      tick(Q);
      scl_m = 1'b1;
      tick(2 * Q);
    end
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic get_bit(output bit b);
    sda_low_m = 1'b0;
    tick(Q);
    b = sda_bus;
    scl_m = 1'b1;
    tick(2 * Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i], glitch);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] v, input bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(ack ? 1'b0 : 1'b1, 1'b0);
  endtask

  initial begin
    bit         ack, b;
    logic [7:0] v;
    logic [3:0] nib;
    int         r0, c0, o0;

    tick(4);
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    expect_v("rst_sda_oe", 16'h0);  observe(16'(sda_oe));
    expect_v("rst_cfg", 16'h00);    observe(16'(config_byte));
    expect_v("rst_cfg_valid", 16'h0); observe(16'(config_valid));
    expect_v("rst_read_done", 16'h0); observe(16'(read_done));
    expect_v("rst_busy", 16'h0);    observe(16'(busy));

    // Single 2-byte read of sample 0xA5C.
    sample_data = 12'hA5C;
    r0 = rd_pulses;
    i2c_start;
    put_byte(8'h51, 1'b0, ack);
    expect_v("rd_addr_ack", 16'h0); observe(16'(ack));
    expect_v("rd_busy", 16'h1);     observe(16'(busy));
    expect_v("rd_byte0", 16'h0A);   get_byte(v, 1'b1); observe(16'(v));
    expect_v("rd_byte1", 16'h5C);   get_byte(v, 1'b0); observe(16'(v));
    i2c_stop;
    expect_v("rd_done_cnt", 16'h1); observe(16'(rd_pulses - r0));
    expect_v("rd_idle_busy", 16'h0); observe(16'(busy));
    expect_v("rd_idle_oe", 16'h0);  observe(16'(sda_oe));

    // Config write.
    c0 = cfg_pulses;
    i2c_start;
    put_byte(8'h50, 1'b0, ack);
    expect_v("wr_addr_ack", 16'h0); observe(16'(ack));
    exp_cfg.push_back(8'h21);
    put_byte(8'h21, 1'b0, ack);
    expect_v("wr_data_ack", 16'h0); observe(16'(ack));
    i2c_stop;
    expect_v("wr_cfg", 16'h21);     observe(16'(config_byte));
    expect_v("wr_cfg_pulses", 16'h1); observe(16'(cfg_pulses - c0));

    // Streaming read: sample changes mid-pair, shadow holds until pair ends.
    sample_data = 12'hA5C;
    r0 = rd_pulses;
    i2c_start;
    put_byte(8'h51, 1'b0, ack);
    expect_v("st_addr_ack", 16'h0); observe(16'(ack));
    expect_v("st_byte0", 16'h0A);   get_byte(v, 1'b1); observe(16'(v));
    sample_data = 12'h123;
    expect_v("st_byte1", 16'h5C);   get_byte(v, 1'b1); observe(16'(v));
    expect_v("st_byte2", 16'h01);   get_byte(v, 1'b1); observe(16'(v));
    expect_v("st_byte3", 16'h23);   get_byte(v, 1'b0); observe(16'(v));
    i2c_stop;
    expect_v("st_done_cnt", 16'h1); observe(16'(rd_pulses - r0));

    // Wrong address and general call are both ignored.
    o0 = oe_hi;
    i2c_start;
    put_byte(8'h53, 1'b0, ack);
    expect_v("wa_nack", 16'h1);     observe(16'(ack));
    expect_v("wa_busy", 16'h0);     observe(16'(busy));
    expect_v("wa_oe_quiet", 16'h0); observe(16'(oe_hi - o0));
    i2c_stop;
    expect_v("wa_stop_busy", 16'h0); observe(16'(busy));
    i2c_start;
    put_byte(8'h00, 1'b0, ack);
    expect_v("gc_nack", 16'h1);     observe(16'(ack));
    i2c_stop;

    // Repeated start after a partial write byte, then a read.
    sample_data = 12'hA5C;
    c0 = cfg_pulses;
    i2c_start;
    put_byte(8'h50, 1'b0, ack);
    expect_v("rs_wr_ack", 16'h0);   observe(16'(ack));
    put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b0); put_bit(1'b1, 1'b0); put_bit(1'b1, 1'b0);
    i2c_start;
    put_byte(8'h51, 1'b0, ack);
    expect_v("rs_rd_ack", 16'h0);   observe(16'(ack));
    expect_v("rs_byte0", 16'h0A);   get_byte(v, 1'b0); observe(16'(v));
    i2c_stop;
    expect_v("rs_cfg_kept", 16'h21); observe(16'(config_byte));
    expect_v("rs_no_cfg", 16'h0);   observe(16'(cfg_pulses - c0));

    // Reset while the responder drives bit 3 of byte0 (0x05 -> bit 3 is 0).
    sample_data = 12'h5A5;
    i2c_start;
    put_byte(8'h51, 1'b0, ack);
    expect_v("rr_addr_ack", 16'h0); observe(16'(ack));
    for (int i = 3; i >= 0; i--) begin
      get_bit(b);
      nib[i] = b;
    end
    expect_v("rr_hi_nibble", 16'h0); observe(16'(nib));
    expect_v("rr_oe_before", 16'h1); observe(16'(sda_oe));
    @(negedge clk);
    rst = 1'b1;
    #2;
    expect_v("rr_oe_async", 16'h0); observe(16'(sda_oe));
    tick(3);
    rst = 1'b0;
    tick(2);
    i2c_stop;
    expect_v("rr_cfg_reset", 16'h00); observe(16'(config_byte));
    i2c_start;
    put_byte(8'h50, 1'b0, ack);
    expect_v("rr_wr_ack", 16'h0);   observe(16'(ack));
    exp_cfg.push_back(8'h3C);
    put_byte(8'h3C, 1'b0, ack);
    expect_v("rr_data_ack", 16'h0); observe(16'(ack));
    i2c_stop;
    expect_v("rr_cfg", 16'h3C);     observe(16'(config_byte));

`ifdef I2C_GLITCH_FILTER_EN
    // 1-clk SCL glitches in both phases of every bit.
    i2c_start;
    put_byte(8'h50, 1'b1, ack);
    expect_v("gl_addr_ack", 16'h0); observe(16'(ack));
    exp_cfg.push_back(8'h77);
    put_byte(8'h77, 1'b1, ack);
    expect_v("gl_data_ack", 16'h0); observe(16'(ack));
    i2c_stop;
    expect_v("gl_cfg", 16'h77);     observe(16'(config_byte));
`endif

    tick(50);
    done = 1'b1;
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
